pwm_nch: RTL

Parametrised multi-channel PWM generator, successor to the single-channel 11-bit PWM used by the motor drive path. All channels share one period counter, which runs in edge-aligned (sawtooth) or center-aligned (triangle) mode. Each channel has a double-buffered duty register that updates only at period boundaries, plus complementary outputs with programmable dead time. It sits between the control loop, which writes duty values, and the gate-driver pins.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_deadtime.sv | 97 +++++++++
 rtl/pwm_nch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default parameters for the multi-channel PWM.
//   pwm_dt_state_e : per-channel dead-time FSM state
//   PWM_*_DEF      : default WIDTH / NCH / DT_W for pwm_nch
package pwm_pkg;

   localparam int unsigned PWM_WIDTH_DEF = 11;
   localparam int unsigned PWM_NCH_DEF   = 2;
   localparam int unsigned PWM_DT_W_DEF  = 6;

   typedef enum logic [1:0] {
      DEAD = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } pwm_dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output stage with dead-time insertion for one channel.
//   clk, rst     : clock, synchronous active-high reset
//   en           : run enable; low forces DEAD with the dead counter cleared
//   raw          : compare result for this channel
//   deadtime     : dead interval length in clk cycles
//   PWM_sig      : registered high-side drive
//   PWM_sig_n    : registered low-side drive (never high together with PWM_sig)
module pwm_deadtime #(
   parameter int unsigned DT_W = pwm_pkg::PWM_DT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            raw,
   input  logic [DT_W-1:0] deadtime,
   output logic            PWM_sig,
   output logic            PWM_sig_n
);
   import pwm_pkg::*;

   pwm_dt_state_e   state, state_nxt;
   logic [DT_W-1:0] dcnt, dcnt_nxt;
   logic [DT_W-1:0] dt_q, dt_nxt;
   logic [DT_W-1:0] lim, cnt_eff;
   logic            raw_q;

   // dcnt==0 marks a fresh dead interval (after reset / en low): use the live
   // deadtime and latch it; otherwise the value latched at entry is used.
   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      dt_nxt    = dt_q;
      lim       = (dcnt == '0) ? deadtime : dt_q;
      cnt_eff   = (raw == raw_q) ? dcnt : '0;
      if (!en) begin
         state_nxt = DEAD;
         dcnt_nxt  = '0;
      end else begin
         case (state)
            HI: begin
               if (!raw) begin
                  if (deadtime == '0) begin
                     state_nxt = LO;
                  end else begin
                     state_nxt = DEAD;
                     dcnt_nxt  = DT_W'(1);
                     dt_nxt    = deadtime;
                  end
               end
            end
            LO: begin
               if (raw) begin
                  if (deadtime == '0) begin
                     state_nxt = HI;
                  end else begin
                     state_nxt = DEAD;
                     dcnt_nxt  = DT_W'(1);
                     dt_nxt    = deadtime;
                  end
               end
            end
            default: begin
               // a raw change inside DEAD restarts the count (cnt_eff = 0)
               if (cnt_eff >= lim) begin
                  state_nxt = raw ? HI : LO;
                  dcnt_nxt  = '0;
               end else begin
                  dcnt_nxt = cnt_eff + DT_W'(1);
                  if (dcnt == '0) begin
                     dt_nxt = deadtime;
                  end
               end
            end
         endcase
      end
   end

   // state register; outputs decoded from the next state so they are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DEAD;
         dcnt      <= '0;
         dt_q      <= '0;
         raw_q     <= 1'b0;
         PWM_sig   <= 1'b0;
         PWM_sig_n <= 1'b0;
      end else begin
         state     <= state_nxt;
         dcnt      <= dcnt_nxt;
         dt_q      <= dt_nxt;
         raw_q     <= raw;
         PWM_sig   <= (state_nxt == HI);
         PWM_sig_n <= (state_nxt == LO);
      end
   end

endmodule

// File: rtl/pwm_nch.sv
// pwm_nch: multi-channel PWM with shared edge/center-aligned counter,
// double-buffered duty registers and per-channel dead-time outputs.
//   clk, rst     : clock, synchronous active-high reset
//   en           : run enable; low holds cnt at 0 and forces outputs 0/0
//   center       : 0 = sawtooth, 1 = triangle; applied at the period boundary
//   deadtime     : dead time in clk cycles
//   duty_in      : duty per channel, channel k at [k*WIDTH +: WIDTH]
//   duty_wr      : strobe capturing duty_in into the shadow registers
//   upd_pending  : shadow written but not yet transferred to active
//   period_start : pulse in the cycle cnt==0 going up
//   PWM_sig      : high-side drive per channel
//   PWM_sig_n    : low-side drive per channel
module pwm_nch #(
   parameter int unsigned WIDTH = pwm_pkg::PWM_WIDTH_DEF,
   parameter int unsigned NCH   = pwm_pkg::PWM_NCH_DEF,
   parameter int unsigned DT_W  = pwm_pkg::PWM_DT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               center,
   input  logic [DT_W-1:0]    deadtime,
   input  logic [NCH*WIDTH-1:0] duty_in,
   input  logic               duty_wr,
   output logic               upd_pending,
   output logic               period_start,
   output logic [NCH-1:0]     PWM_sig,
   output logic [NCH-1:0]     PWM_sig_n
);
   import pwm_pkg::*;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]            cnt, cnt_nxt;
   logic                        dir_up, dir_nxt;
   logic                        mode_q, mode_nxt;
   logic                        wrap;
   logic [NCH-1:0][WIDTH-1:0]   shadow, duty_act;
   logic [NCH-1:0]              raw;

   // next counter value; wrap marks the edge into cnt==0 going up
   always_comb begin
      cnt_nxt  = cnt;
      dir_nxt  = dir_up;
      mode_nxt = mode_q;
      wrap     = 1'b0;
      if (!en) begin
         cnt_nxt  = '0;
         dir_nxt  = 1'b1;
         mode_nxt = center;
      end else if (!mode_q) begin
         dir_nxt = 1'b1;
         if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
         end else begin
            cnt_nxt = cnt + WIDTH'(1);
         end
      end else if (dir_up) begin
         if (cnt == CNT_MAX) begin
            cnt_nxt = cnt - WIDTH'(1);
            dir_nxt = 1'b0;
         end else begin
            cnt_nxt = cnt + WIDTH'(1);
         end
      end else begin
         cnt_nxt = cnt - WIDTH'(1);
         if (cnt == WIDTH'(1)) begin
            dir_nxt = 1'b1;
            wrap    = 1'b1;
         end
      end
      if (wrap) begin
         mode_nxt = center;
      end
   end

   // counter, direction, mode; period_start is registered from the wrap edge,
   // so the idle cnt==0 before the first run period does not pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         dir_up       <= 1'b1;
         mode_q       <= 1'b0;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         dir_up       <= dir_nxt;
         mode_q       <= mode_nxt;
         period_start <= wrap;
      end
   end

   // duty double buffering; a write on the wrap edge bypasses the shadow
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow      <= '0;
         duty_act    <= '0;
         upd_pending <= 1'b0;
      end else if (wrap) begin
         upd_pending <= 1'b0;
         if (duty_wr) begin
            shadow   <= duty_in;
            duty_act <= duty_in;
         end else if (upd_pending) begin
            duty_act <= shadow;
         end
      end else if (duty_wr) begin
         shadow      <= duty_in;
         upd_pending <= 1'b1;
      end
   end

   // per-channel compare and dead-time stage
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign raw[k] = (cnt < duty_act[k]);

      pwm_deadtime #(.DT_W(DT_W)) u_dt (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .raw       (raw[k]),
         .deadtime  (deadtime),
         .PWM_sig   (PWM_sig[k]),
         .PWM_sig_n (PWM_sig_n[k])
      );
   end

endmodule
